// File: rtl/latch_cmp_pkg.sv
// Shared types and constants for the latch comparator sequencer.
package latch_cmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRECH = 3'd1,
    S_EVAL  = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int DEF_RST_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 8;
  localparam int DEF_SYNC_STAGES    = 2;

  localparam int CNT_W   = 8;  // phase counter, covers RST_CYCLES and TIMEOUT_CYCLES
  localparam int BURST_W = 8;  // remaining comparisons and ones count
  localparam int VOTE_W  = 2;  // ones seen among the first two sub-strobes

  function automatic logic majority3(input logic [VOTE_W-1:0] votes, input logic last_vote);
    return ({1'b0, votes} + {2'b00, last_vote}) >= 3'd2;
  endfunction

endpackage

// File: rtl/cmp_sync.sv
// Multi-flop synchroniser for one asynchronous comparator output; resets to 0.
module cmp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/latch_cmp_sequencer.sv
// Precharge/strobe sequencer for the dynamic latch comparator with burst bookkeeping.
// Optional macro CMP_MAJORITY_EN: each comparison becomes a 2-of-3 vote over three strobes.
module latch_cmp_sequencer
  import latch_cmp_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cmp_valid,
  input  logic               cmp_op,
  output logic               cmp_rst,
  output logic               cmp_en,
  output logic               busy,
  output logic               done,
  output logic               last_bit,
  output logic [BURST_W-1:0] ones_count,
  output logic               timeout
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_PRECH = S_PRECH;
  localparam logic [2:0] ST_EVAL  = S_EVAL;
  localparam logic [2:0] ST_CAPT  = S_CAPT;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam logic [CNT_W-1:0]   PRECH_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   EVAL_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               suppress_q, suppress_d;
  logic               last_bit_q, last_bit_d;
  logic [BURST_W-1:0] ones_q, ones_d;
  logic               timeout_q, timeout_d;
  logic               cmp_rst_q, cmp_en_q, busy_q, done_q;
  logic               valid_s, op_s;

`ifdef CMP_MAJORITY_EN
  logic [1:0]        sub_q, sub_d;
  logic [VOTE_W-1:0] votes_q, votes_d;
  logic              cap_bit, maj_bit;
  assign cap_bit = op_s & ~suppress_q;
`endif

  cmp_sync #(.STAGES(SYNC_STAGES)) u_sync_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cmp_valid),
    .q_o   (valid_s)
  );

  cmp_sync #(.STAGES(SYNC_STAGES)) u_sync_op (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cmp_op),
    .q_o   (op_s)
  );

  // start is a single-cycle request with no ready: it is taken only in IDLE with ena high,
  // otherwise dropped. done is a single-cycle valid with no backpressure.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    suppress_d  = suppress_q;
    last_bit_d  = last_bit_q;
    ones_d      = ones_q;
    timeout_d   = timeout_q;
`ifdef CMP_MAJORITY_EN
    sub_d       = sub_q;
    votes_d     = votes_q;
    maj_bit     = 1'b0;
`endif
    if (state_q != ST_IDLE && !ena) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && ena) begin
            remaining_d = burst_len;
            ones_d      = '0;
            timeout_d   = 1'b0;
            cnt_d       = '0;
`ifdef CMP_MAJORITY_EN
            sub_d       = '0;
            votes_d     = '0;
`endif
            state_d     = (burst_len == '0) ? ST_DONE : ST_PRECH;
          end
        end
        ST_PRECH: begin
          if (cnt_q == PRECH_LAST) begin
            cnt_d      = '0;
            suppress_d = 1'b0;
            state_d    = ST_EVAL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_EVAL: begin
          if (valid_s) begin
            cnt_d   = '0;
            state_d = ST_CAPT;
          end else if (cnt_q == EVAL_LAST) begin
            cnt_d      = '0;
            suppress_d = 1'b1;
            timeout_d  = 1'b1;
`ifndef CMP_MAJORITY_EN
            last_bit_d = 1'b0;
`endif
            state_d    = ST_CAPT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_CAPT: begin
`ifdef CMP_MAJORITY_EN
          if (sub_q != 2'd2) begin
            sub_d   = sub_q + 2'd1;
            votes_d = votes_q + {1'b0, cap_bit};
            state_d = ST_PRECH;
          end else begin
            maj_bit     = majority3(votes_q, cap_bit);
            sub_d       = '0;
            votes_d     = '0;
            last_bit_d  = maj_bit;
            ones_d      = ones_q + {{(BURST_W-1){1'b0}}, maj_bit};
            remaining_d = remaining_q - BURST_ONE;
            state_d     = (remaining_q == BURST_ONE) ? ST_DONE : ST_PRECH;
          end
`else
          if (!suppress_q) begin
            last_bit_d = op_s;
            ones_d     = ones_q + {{(BURST_W-1){1'b0}}, op_s};
          end
          remaining_d = remaining_q - BURST_ONE;
          state_d     = (remaining_q == BURST_ONE) ? ST_DONE : ST_PRECH;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Phase outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      suppress_q  <= 1'b0;
      last_bit_q  <= 1'b0;
      ones_q      <= '0;
      timeout_q   <= 1'b0;
      cmp_rst_q   <= 1'b1;
      cmp_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      suppress_q  <= suppress_d;
      last_bit_q  <= last_bit_d;
      ones_q      <= ones_d;
      timeout_q   <= timeout_d;
      cmp_rst_q   <= (state_d != ST_EVAL);
      cmp_en_q    <= (state_d == ST_EVAL);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

`ifdef CMP_MAJORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      votes_q <= '0;
    end else begin
      sub_q   <= sub_d;
      votes_q <= votes_d;
    end
  end
`endif

  assign cmp_rst    = cmp_rst_q;
  assign cmp_en     = cmp_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign last_bit   = last_bit_q;
  assign ones_count = ones_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_latch_cmp_sequencer.sv
// Bench for latch_cmp_sequencer: comparator model reacting to strobes, burst-level reference model.
module tb_latch_cmp_sequencer;

  localparam int RST_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int SYNC_STAGES    = 2;
`ifdef CMP_MAJORITY_EN
  localparam int SUBS = 3;
`else
  localparam int SUBS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       cmp_valid = 1'b0;
  logic       cmp_op = 1'b0;
  logic       cmp_rst, cmp_en, busy, done, last_bit, timeout;
  logic [7:0] ones_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    int   delay;
    logic bitv;
    logic never;
  } strobe_t;

  strobe_t    plan_q[$];
  strobe_t    exp_plan[$];
  logic [7:0] exp_q[$];
  logic [7:0] en_len_q[$];
  strobe_t    cur;
  int         en_run = 0;
  int         en_pulses = 0;

  latch_cmp_sequencer #(
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .burst_len  (burst_len),
    .cmp_valid  (cmp_valid),
    .cmp_op     (cmp_op),
    .cmp_rst    (cmp_rst),
    .cmp_en     (cmp_en),
    .busy       (busy),
    .done       (done),
    .last_bit   (last_bit),
    .ones_count (ones_count),
    .timeout    (timeout)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparator model ----------------
  // Decision appears 'delay' cycles into a strobe; a 'never' strobe stays metastable.
  always @(negedge clk) begin
    total++;
    if (cmp_en && cmp_rst) begin
      bad++;
      $display("FAIL en_rst_overlap: cmp_en=%0b cmp_rst=%0b, must not both be 1", cmp_en, cmp_rst);
    end
    if (!rst_n || cmp_rst || !cmp_en) begin
      cmp_valid = 1'b0;
      if (en_run > 0) begin
        en_len_q.push_back(8'(en_run));
        en_run = 0;
      end
    end else begin
      if (en_run == 0) begin
        en_pulses++;
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else begin
          cur.delay = 0; cur.bitv = 1'b0; cur.never = 1'b1;
        end
      end
      en_run++;
      if (!cur.never && en_run == cur.delay) begin
        cmp_valid = 1'b1;
        cmp_op    = cur.bitv;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_plans();
    plan_q.delete();
    exp_plan.delete();
    exp_q.delete();
    en_len_q.delete();
  endtask

  task automatic add_strobe(input int delay, input logic b, input logic never);
    strobe_t s;
    s.delay = delay; s.bitv = b; s.never = never;
    plan_q.push_back(s);
    exp_plan.push_back(s);
  endtask

  task automatic start_burst(input int len);
    tick();
    burst_len = 8'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Each strobe costs precharge + strobe time + one capture cycle; decision is the majority of SUBS bits.
  function automatic void ref_burst(input int len, output int ones, output logic last,
                                    output logic to, output int cyc);
    int      votes;
    logic    dec;
    strobe_t p;
    ones = 0; last = 1'b0; to = 1'b0; cyc = 0;
    exp_q.delete();
    for (int c = 0; c < len; c++) begin
      votes = 0;
      for (int s = 0; s < SUBS; s++) begin
        p = exp_plan[c*SUBS + s];
        if (p.never) to = 1'b1;
        else votes += int'(p.bitv);
        exp_q.push_back(8'(p.never ? TIMEOUT_CYCLES : p.delay + SYNC_STAGES));
        cyc += RST_CYCLES + (p.never ? TIMEOUT_CYCLES : p.delay + SYNC_STAGES) + 1;
      end
      dec = (2*votes > SUBS);
      ones += int'(dec);
      last = dec;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) tick();
    total++;
    if ({cmp_rst, cmp_en, busy, done, last_bit, timeout} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl: got rst/en/busy/done/last/to=%b want 100000",
               {cmp_rst, cmp_en, busy, done, last_bit, timeout});
    end
    total++;
    if (ones_count !== 8'd0) begin
      bad++; $display("FAIL reset_ones: got %0d want 0", ones_count);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if ({cmp_rst, cmp_en, busy, done} !== 4'b1000) begin
      bad++; $display("FAIL idle_after_reset: got rst/en/busy/done=%b want 1000", {cmp_rst, cmp_en, busy, done});
    end
  endtask

  task automatic test_burst4();
    logic seen, last_e, to_e;
    int cyc, ones_e, cyc_e, p0;
    logic ops [4];
    logic [7:0] a, e;
    ops[0] = 1'b1; ops[1] = 1'b0; ops[2] = 1'b1; ops[3] = 1'b1;
    clear_plans();
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < SUBS; s++) add_strobe(1, ops[c], 1'b0);
    ref_burst(4, ones_e, last_e, to_e, cyc_e);
    p0 = en_pulses;
    start_burst(4);
    tick(); tick();
    burst_len = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(800, seen, cyc);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL burst4_done: got no done want done"); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL burst4_busy_at_done: got %0b want 1", busy); end
    total++;
    if (ones_count !== 8'(ones_e)) begin bad++; $display("FAIL burst4_ones: got %0d want %0d", ones_count, ones_e); end
    total++;
    if (last_bit !== last_e) begin bad++; $display("FAIL burst4_last: got %0b want %0b", last_bit, last_e); end
    total++;
    if (timeout !== to_e) begin bad++; $display("FAIL burst4_timeout: got %0b want %0b", timeout, to_e); end
    total++;
    if (en_pulses - p0 != 4*SUBS) begin bad++; $display("FAIL burst4_strobes: got %0d want %0d", en_pulses - p0, 4*SUBS); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (en_len_q.size() > 0) ? en_len_q.pop_front() : 8'd0;
      total++;
      if (a !== e) begin bad++; $display("FAIL burst4_en_len: got %0d want %0d", a, e); end
    end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL burst4_after: got done/busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_timeout();
    logic seen, last_e, to_e;
    int cyc, ones_e, cyc_e;
    logic [7:0] a, e;
    clear_plans();
    for (int s = 0; s < SUBS; s++) add_strobe($urandom_range(1, 5), 1'b1, 1'b0);
    for (int s = 0; s < SUBS; s++) add_strobe(1, 1'b1, 1'b1);
    ref_burst(2, ones_e, last_e, to_e, cyc_e);
    start_burst(2);
    wait_done(800, seen, cyc);
    total++;
    if (seen !== 1'b1 || cyc != cyc_e) begin
      bad++; $display("FAIL timeout_latency: got seen=%0b cycles=%0d want seen=1 cycles=%0d", seen, cyc, cyc_e);
    end
    total++;
    if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %0b want 1", timeout); end
    total++;
    if (ones_count !== 8'(ones_e)) begin bad++; $display("FAIL timeout_ones: got %0d want %0d", ones_count, ones_e); end
    total++;
    if (last_bit !== last_e) begin bad++; $display("FAIL timeout_last: got %0b want %0b", last_bit, last_e); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (en_len_q.size() > 0) ? en_len_q.pop_front() : 8'd0;
      total++;
      if (a !== e) begin bad++; $display("FAIL timeout_en_len: got %0d want %0d", a, e); end
    end
    tick();
  endtask

  task automatic test_zero();
    int p0;
    clear_plans();
    p0 = en_pulses;
    start_burst(0);
    total++;
    if ({done, busy} !== 2'b11) begin bad++; $display("FAIL zero_done: got done/busy=%b want 11", {done, busy}); end
    total++;
    if ({ones_count, timeout} !== 9'd0) begin
      bad++; $display("FAIL zero_cleared: got ones=%0d timeout=%0b want 0/0", ones_count, timeout);
    end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_after: got done/busy=%b want 00", {done, busy}); end
    total++;
    if (en_pulses != p0) begin bad++; $display("FAIL zero_strobes: got %0d want 0", en_pulses - p0); end
  endtask

  task automatic test_ena_drop();
    int n, p0;
    logic saw_done;
    clear_plans();
    for (int c = 0; c < 3; c++)
      for (int s = 0; s < SUBS; s++) add_strobe(2, 1'b1, 1'b0);
    p0 = en_pulses;
    start_burst(3);
    n = 0;
    while (en_len_q.size() < SUBS && n < 400) begin tick(); n++; end
    tick();
    ena = 1'b0;
    tick();
    total++;
    if ({cmp_rst, cmp_en, busy, done} !== 4'b1000) begin
      bad++; $display("FAIL ena_drop_idle: got rst/en/busy/done=%b want 1000", {cmp_rst, cmp_en, busy, done});
    end
    total++;
    if (ones_count !== 8'd1 || last_bit !== 1'b1) begin
      bad++; $display("FAIL ena_drop_partial: got ones=%0d last=%0b want 1/1", ones_count, last_bit);
    end
    saw_done = 1'b0;
    repeat (20) begin tick(); if (done) saw_done = 1'b1; end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL ena_drop_no_done: got done pulse want none"); end
    total++;
    if (en_pulses - p0 != SUBS) begin bad++; $display("FAIL ena_drop_strobes: got %0d want %0d", en_pulses - p0, SUBS); end
    ena = 1'b1;
    clear_plans();
    tick();
  endtask

  task automatic test_reset_mid_eval();
    int n, p0, cyc;
    logic seen;
    clear_plans();
    for (int s = 0; s < SUBS; s++) add_strobe(1, 1'b1, 1'b0);
    for (int s = 0; s < SUBS; s++) add_strobe(5, 1'b0, 1'b0);
    p0 = en_pulses;
    start_burst(2);
    n = 0;
    while ((en_pulses - p0 < SUBS + 1 || !cmp_en) && n < 400) begin tick(); n++; end
    total++;
    if (cmp_en !== 1'b1 || ones_count !== 8'd1) begin
      bad++; $display("FAIL mid_eval_setup: got cmp_en=%0b ones=%0d want 1/1", cmp_en, ones_count);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cmp_rst, cmp_en, busy, done, last_bit, timeout} !== 6'b100000 || ones_count !== 8'd0) begin
      bad++; $display("FAIL mid_eval_reset: got rst/en/busy/done/last/to=%b ones=%0d want 100000 ones=0",
                      {cmp_rst, cmp_en, busy, done, last_bit, timeout}, ones_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    clear_plans();
    for (int s = 0; s < SUBS; s++) add_strobe(3, 1'b1, 1'b0);
    start_burst(1);
    wait_done(400, seen, cyc);
    total++;
    if (seen !== 1'b1 || ones_count !== 8'd1 || last_bit !== 1'b1) begin
      bad++; $display("FAIL post_reset_burst: got seen=%0b ones=%0d last=%0b want 1/1/1", seen, ones_count, last_bit);
    end
    tick();
  endtask

`ifdef CMP_MAJORITY_EN
  task automatic test_majority();
    logic seen;
    int cyc, p0;
    clear_plans();
    add_strobe(1, 1'b1, 1'b0);
    add_strobe(1, 1'b0, 1'b0);
    add_strobe(1, 1'b1, 1'b0);
    p0 = en_pulses;
    start_burst(1);
    wait_done(400, seen, cyc);
    total++;
    if (seen !== 1'b1 || en_pulses - p0 != 3) begin
      bad++; $display("FAIL majority_strobes: got seen=%0b strobes=%0d want 1/3", seen, en_pulses - p0);
    end
    total++;
    if (last_bit !== 1'b1 || ones_count !== 8'd1) begin
      bad++; $display("FAIL majority_result: got last=%0b ones=%0d want 1/1", last_bit, ones_count);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic seen, last_e, to_e;
    int cyc, ones_e, cyc_e, len;
    logic [7:0] a, e;
    for (int r = 0; r < 8; r++) begin
      clear_plans();
      len = $urandom_range(1, 5);
      for (int k = 0; k < len*SUBS; k++)
        add_strobe($urandom_range(1, 5), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      ref_burst(len, ones_e, last_e, to_e, cyc_e);
      start_burst(len);
      wait_done(1000, seen, cyc);
      total++;
      if (seen !== 1'b1 || cyc != cyc_e) begin
        bad++; $display("FAIL rand%0d_latency: got seen=%0b cycles=%0d want seen=1 cycles=%0d", r, seen, cyc, cyc_e);
      end
      total++;
      if (ones_count !== 8'(ones_e) || last_bit !== last_e || timeout !== to_e) begin
        bad++; $display("FAIL rand%0d_result: got ones=%0d last=%0b to=%0b want %0d/%0b/%0b",
                        r, ones_count, last_bit, timeout, ones_e, last_e, to_e);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = (en_len_q.size() > 0) ? en_len_q.pop_front() : 8'd0;
        total++;
        if (a !== e) begin bad++; $display("FAIL rand%0d_en_len: got %0d want %0d", r, a, e); end
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_burst4();
    test_timeout();
    test_zero();
    test_ena_drop();
    test_reset_mid_eval();
`ifdef CMP_MAJORITY_EN
    test_majority();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
